load_store_unit: RTL and testbench

//   Sits between the multi-cycle control/datapath and data_memory, which always moves full 32-bit words and returns read data one clock after mem_read.

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 132 +++++++++++++
 tb/tb_load_store_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// CPU-side request/response and data_memory-side signals of the load/store unit.
// slave is the LSU view; master is the view of the control path plus memory around it.
interface load_store_unit_if;
   logic        req;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] load_data;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req, is_store, funct3, addr, store_data, mem_rdata,
      output busy, done, err, load_data, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output req, is_store, funct3, addr, store_data, mem_rdata,
      input  busy, done, err, load_data, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide data memory with one-cycle read latency.
// Sub-word stores use read-modify-write; loads are sign/zero extended from the addressed lane.
module load_store_unit #(
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic              clk,
   input  logic              reset,
   load_store_unit_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      LD_RD,
      LD_FMT,
      ST_WR,
      RMW_RD,
      RMW_WR,
      ERR
   } state_t;

   state_t      state, next_state;
   logic [31:0] addr_q, data_q;
   logic [2:0]  f3_q;

   logic        accept;
   logic [2:0]  size;
   logic [32:0] end_addr;
   logic        misaligned, out_of_range, illegal, reject;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] ld_ext, merged;

   assign accept = (state == IDLE) && bus.req;

   // Request checks, evaluated on the live inputs at accept time
   always_comb begin
      case (bus.funct3[1:0])
         2'b00:   size = 3'd1;
         2'b01:   size = 3'd2;
         default: size = 3'd4;
      endcase
      end_addr     = {1'b0, bus.addr} + {30'b0, size};
      out_of_range = end_addr > 33'(MEM_BYTES);
      misaligned   = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                     ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
      if (bus.is_store)
         illegal = bus.funct3 > 3'b010;
      else
         illegal = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
      reject = misaligned || out_of_range || illegal;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = IDLE;
      case (state)
         IDLE: begin
            if (!bus.req)                   next_state = IDLE;
            else if (reject)                next_state = ERR;
            else if (!bus.is_store)         next_state = LD_RD;
            else if (bus.funct3 == 3'b010)  next_state = ST_WR;
            else                            next_state = RMW_RD;
         end
         LD_RD:   next_state = LD_FMT;
         RMW_RD:  next_state = RMW_WR;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      lane_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  ld_ext = {24'h0, lane_b};
         3'b101:  ld_ext = {16'h0, lane_h};
         default: ld_ext = bus.mem_rdata;
      endcase
      merged = bus.mem_rdata;
      if (f3_q[0])
         merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      else
         merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
   end

   always_comb begin
      bus.busy      = state != IDLE;
      bus.mem_read  = (state == LD_RD) || (state == RMW_RD);
      bus.mem_write = (state == ST_WR) || (state == RMW_WR);
      bus.mem_addr  = {addr_q[31:2], 2'b00};
      bus.mem_wdata = (state == RMW_WR) ? merged : data_q;
   end

   // A rejected request raises done/err on the accept edge so the pulse lands
   // one cycle after accept; ERR then only spends that cycle returning to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q        <= '0;
         data_q        <= '0;
         f3_q          <= '0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.load_data <= '0;
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         if (accept) begin
            addr_q <= bus.addr;
            data_q <= bus.store_data;
            f3_q   <= bus.funct3;
            if (reject) begin
               bus.done <= 1'b1;
               bus.err  <= 1'b1;
            end
         end
         case (state)
            LD_FMT: begin
               bus.load_data <= ld_ext;
               bus.done      <= 1'b1;
            end
            ST_WR, RMW_WR: bus.done <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: word memory model on the bus and a
// byte-array reference that predicts results, latency and memory traffic.
module tb_load_store_unit;
   localparam int unsigned MEM_BYTES = 4096;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic fill = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if bus ();

   load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] dmem [0:1023];
   byte unsigned ref_mem [0:MEM_BYTES-1];
   logic [31:0] last_ld = '0;

   function automatic logic [31:0] init_word(int unsigned i);
      if (i == 4) return 32'hDEADBEEF;
      return (i * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // data_memory: full words, read data registered one cycle after mem_read
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 1024; i++) dmem[i] <= init_word(i);
      end else begin
         if (bus.mem_write) dmem[bus.mem_addr[11:2]] <= bus.mem_wdata;
         if (bus.mem_read)  bus.mem_rdata <= dmem[bus.mem_addr[11:2]];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int unsigned ref_size(logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit ref_reject(bit st, logic [2:0] f3, logic [31:0] a);
      int unsigned sz = ref_size(f3);
      bit bad_f3 = st ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      bit mis = (sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0);
      bit oor = (longint'({32'b0, a}) + longint'(sz)) > longint'(MEM_BYTES);
      return bad_f3 || mis || oor;
   endfunction

   function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
      logic [31:0] v = 0;
      for (int k = 0; k < int'(ref_size(f3)); k++) v = v + (32'(ref_mem[a + k]) << (8 * k));
      if (f3 == 3'b000 && v >= 128)   v = v + 32'hFFFFFF00;
      if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF0000;
      return v;
   endfunction

   function automatic logic [31:0] ref_word(logic [31:0] a);
      logic [31:0] v = 0;
      for (int k = 0; k < 4; k++) v = v + (32'(ref_mem[a + k]) << (8 * k));
      return v;
   endfunction

   task automatic ref_store(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
      for (int k = 0; k < int'(ref_size(f3)); k++) ref_mem[a + k] = 8'((d >> (8 * k)) & 32'hFF);
   endtask

   // One request; b2b drives it in the current (done) cycle, poke pulses req while busy.
   task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input bit b2b, input bit poke, output bit ok);
      int done_c = 0, rd_c = 0, wr_c = 0, nrd = 0, nwr = 0, w = 0;
      logic [31:0] wd = '0, ld = '0, ma = '0;
      logic e = 1'b0;
      bit rej = ref_reject(st, f3, a);
      int exp_lat = rej ? 1 : (!st ? 3 : (f3 == 3'b010 ? 2 : 3));
      if (!b2b) begin
         @(negedge clk);
         while (bus.busy && w < 10) begin
            @(negedge clk);
            w++;
         end
         check("idle_before_req", 32'(bus.busy), 32'd0);
         check("done_one_cycle", {30'b0, bus.done, bus.err}, 32'd0);
      end
      bus.req = 1'b1; bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.store_data = d;
      @(posedge clk);
      #1 bus.req = 1'b0;
      for (int c = 1; c <= 8 && done_c == 0; c++) begin
         @(negedge clk);
         if (poke && c == 1) begin
            bus.req = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b010;
         end
         if (poke && c == 2) bus.req = 1'b0;
         if (bus.mem_read) begin
            nrd++;
            if (rd_c == 0) begin rd_c = c; ma = bus.mem_addr; end
         end
         if (bus.mem_write) begin
            nwr++;
            if (wr_c == 0) begin wr_c = c; wd = bus.mem_wdata; ma = bus.mem_addr; end
         end
         if (bus.done) begin
            done_c = c; e = bus.err; ld = bus.load_data;
         end
      end
      bus.req = 1'b0;
      check("done_latency", 32'(done_c), 32'(exp_lat));
      check("err", 32'(e), 32'(rej));
      if (rej) begin
         check("err_no_mem_access", 32'(nrd + nwr), 32'd0);
      end else if (!st) begin
         last_ld = ref_load(f3, a);
         check("load_mem_read_cycle", 32'(rd_c), 32'd1);
         check("load_access_count", 32'(nrd * 16 + nwr), 32'd16);
         check("load_mem_addr", ma, a & 32'hFFFFFFFC);
      end else begin
         ref_store(f3, a, d);
         check("store_write_cycle", 32'(wr_c), f3 == 3'b010 ? 32'd1 : 32'd2);
         check("store_access_count", 32'(nrd * 16 + nwr), f3 == 3'b010 ? 32'd1 : 32'd17);
         check("store_mem_addr", ma, a & 32'hFFFFFFFC);
         check("store_wdata", wd, ref_word(a & 32'hFFFFFFFC));
      end
      check("load_data", ld, last_ld);
      ok = !rej && done_c != 0;
   endtask

   initial begin
      bit ok, prev_ok;
      int nwr, nd;
      bus.req = 1'b0; bus.is_store = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.store_data = '0;
      for (int unsigned i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'((init_word(i / 4) >> (8 * (i % 4))) & 32'hFF);
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done_err", {30'b0, bus.done, bus.err}, 32'd0);
      check("rst_load_data", bus.load_data, 32'd0);
      check("rst_mem_rw", {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      fill = 1'b0;
      reset = 1'b0;

      do_op(0, 3'b010, 32'h10, 0, 0, 0, ok);
      do_op(0, 3'b000, 32'h13, 0, 0, 0, ok);
      do_op(0, 3'b100, 32'h13, 0, 0, 0, ok);
      do_op(0, 3'b001, 32'h12, 0, 0, 0, ok);
      do_op(0, 3'b101, 32'h10, 0, 0, 0, ok);
      do_op(1, 3'b000, 32'h11, 32'hAA, 0, 0, ok);
      do_op(1, 3'b001, 32'h12, 32'h1234, 0, 0, ok);
      do_op(1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 0, ok);
      do_op(0, 3'b010, 32'h12, 0, 0, 0, ok);
      do_op(1, 3'b001, 32'h11, 32'h5555, 0, 0, ok);
      do_op(0, 3'b010, 32'hFFFC, 0, 0, 0, ok);
      do_op(0, 3'b010, 32'hFFC, 0, 0, 0, ok);
      do_op(0, 3'b010, 32'h1000, 0, 0, 0, ok);
      do_op(0, 3'b011, 32'h10, 0, 0, 0, ok);
      do_op(1, 3'b100, 32'h10, 32'h1, 0, 0, ok);
      do_op(0, 3'b010, 32'h20, 0, 0, 1, ok);
      if (ok) do_op(0, 3'b010, 32'h10, 0, 1, 0, ok);

      // reset while the read half of a read-modify-write is in flight
      @(negedge clk);
      bus.req = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h40; bus.store_data = 32'h77;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      nwr = 0; nd = 0;
      repeat (4) begin
         #1 nwr += int'(bus.mem_write); nd += int'(bus.done);
         @(negedge clk);
      end
      check("abort_no_write", 32'(nwr), 32'd0);
      check("abort_no_done", 32'(nd), 32'd0);
      check("abort_load_data", bus.load_data, 32'd0);
      reset = 1'b0;
      last_ld = '0;
      do_op(0, 3'b010, 32'h40, 0, 0, 0, ok);

      prev_ok = ok;
      for (int n = 0; n < 200; n++) begin
         bit st = 1'($urandom_range(0, 1));
         logic [2:0] f3 = 3'($urandom_range(0, 7));
         logic [31:0] a;
         int sel = $urandom_range(0, 9);
         if (sel == 0)      a = $urandom;
         else if (sel == 1) a = MEM_BYTES - 4 + $urandom_range(0, 7);
         else               a = $urandom_range(0, MEM_BYTES - 1);
         if (sel >= 5) a = a & ~(32'(ref_size(f3)) - 1);
         do_op(st, f3, a, $urandom, prev_ok && ($urandom_range(0, 3) == 0), 0, ok);
         prev_ok = ok;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
